// File: rtl/aes_mem_driver.sv
`default_nettype none
// ============================================================================
// Module   : aes_mem_driver
// Purpose  : Host-side initiator for the shared AES scratch memory. Loads an
//            input word stream into the input region, zero-pads it to whole
//            128-bit blocks and appends the 0xDEADBEEF terminator. It then
//            runs the AES engine through its control register, reads the
//            result words back from the output region and streams them out.
//            The memory port belongs to this block whenever aes_ctrl_out is
//            zero.
// Ports    : clk_in, rst_in            clock, async active-high reset
//            mode_in                   0 = encrypt, 1 = decrypt (first word)
//            s_data/valid/last_in,
//            s_ready_out               input word stream
//            m_data/valid/last_out,
//            m_ready_in                result word stream
//            mem_addr/we/data_out,
//            mem_data_in               shared scratch memory port
//            aes_ctrl_out,
//            aes_complete_in           engine control / completion
//            busy_out, done_out,
//            err_out                   status (err_out is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module aes_mem_driver #(
  parameter int IN_BASE    = 0,
  parameter int OUT_BASE   = 257,
  parameter int MAX_WORDS  = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mode_in,
  input  logic [31:0] s_data_in,
  input  logic        s_valid_in,
  input  logic        s_last_in,
  output logic        s_ready_out,
  output logic [31:0] m_data_out,
  output logic        m_valid_out,
  output logic        m_last_out,
  input  logic        m_ready_in,
  output logic [9:0]  mem_addr_out,
  output logic [3:0]  mem_we_out,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  aes_ctrl_out,
  input  logic        aes_complete_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);

  localparam logic [31:0] c_term_word = 32'hDEADBEEF;
  localparam logic [9:0]  c_in_base   = 10'(IN_BASE);
  localparam logic [9:0]  c_out_base  = 10'(OUT_BASE);
  localparam logic [8:0]  c_max_words = 9'(MAX_WORDS);
  localparam int          c_wait_w    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(RD_LATENCY - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_PAD      = 4'd2,
    ST_TERM     = 4'd3,
    ST_RUN      = 4'd4,
    ST_RELEASE  = 4'd5,
    ST_RD_ISSUE = 4'd6,
    ST_RD_WAIT  = 4'd7,
    ST_EMIT     = 4'd8,
    ST_FIN      = 4'd9
  } state_t;

  // Current-state registers
  state_t              r_state;
  logic [8:0]          r_n;
  logic [8:0]          r_k;
  logic [c_wait_w-1:0] r_wait;
  logic                r_mode;
  logic [31:0]         r_rdata;

  // Registered outputs
  logic        r_s_ready;
  logic [31:0] r_m_data;
  logic        r_m_valid;
  logic        r_m_last;
  logic [9:0]  r_mem_addr;
  logic [3:0]  r_mem_we;
  logic [31:0] r_mem_data;
  logic [2:0]  r_aes_ctrl;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  // Next-state values
  state_t              w_state;
  logic [8:0]          w_n;
  logic [8:0]          w_k;
  logic [c_wait_w-1:0] w_wait;
  logic                w_mode;
  logic [31:0]         w_rdata;
  logic [31:0]         w_m_data;
  logic                w_m_valid;
  logic                w_m_last;
  logic [9:0]          w_mem_addr;
  logic [3:0]          w_mem_we;
  logic [31:0]         w_mem_data;
  logic [2:0]          w_aes_ctrl;
  logic                w_done;
  logic                w_err;
  logic                w_hs;
  logic [9:0]          w_in_addr;
  logic [2:0]          w_run_ctrl;

  assign w_hs       = s_valid_in && r_s_ready;
  assign w_in_addr  = c_in_base + {1'b0, r_n};
  assign w_run_ctrl = r_mode ? 3'b010 : 3'b001;

  always_comb begin
    w_state    = r_state;
    w_n        = r_n;
    w_k        = r_k;
    w_wait     = r_wait;
    w_mode     = r_mode;
    w_rdata    = r_rdata;
    w_m_data   = r_m_data;
    w_m_valid  = r_m_valid;
    w_m_last   = r_m_last;
    w_mem_addr = r_mem_addr;
    w_mem_we   = 4'h0;
    w_mem_data = 32'h0;
    w_aes_ctrl = 3'b000;
    w_done     = 1'b0;
    w_err      = r_err;

    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_hs) begin
          if (r_state == ST_IDLE) begin
            w_mode = mode_in;
            w_err  = 1'b0;
          end
          if (s_data_in == c_term_word) begin
            // A payload word equal to the terminator would truncate the
            // engine's scan; abort without writing it.
            w_err   = 1'b1;
            w_state = ST_FIN;
            w_done  = 1'b1;
          end else begin
            w_mem_addr = w_in_addr;
            w_mem_we   = 4'hf;
            w_mem_data = s_data_in;
            w_n        = r_n + 9'd1;
            if (s_last_in) begin
              w_state = ST_PAD;
            end else if (w_n == c_max_words) begin
              w_err   = 1'b1;
              w_state = ST_PAD;
            end else begin
              w_state = ST_LOAD;
            end
          end
        end
      end

      ST_PAD: begin
        w_mem_addr = w_in_addr;
        w_mem_we   = 4'hf;
        if (r_n[1:0] != 2'b00) begin
          w_mem_data = 32'h0;
          w_n        = r_n + 9'd1;
        end else begin
          // The terminator write is registered here so it is on the bus
          // during TERM, leaving TERM->RUN free of any write overlap.
          w_mem_data = c_term_word;
          w_state    = ST_TERM;
        end
      end

      ST_TERM: begin
        w_mem_addr = 10'd0;
        w_aes_ctrl = w_run_ctrl;
        w_state    = ST_RUN;
      end

      ST_RUN: begin
        w_mem_addr = 10'd0;
        if (aes_complete_in) begin
          w_state = ST_RELEASE;
        end else begin
          w_aes_ctrl = w_run_ctrl;
        end
      end

      ST_RELEASE: begin
        w_k        = 9'd0;
        w_mem_addr = c_out_base;
        w_state    = ST_RD_ISSUE;
      end

      ST_RD_ISSUE: begin
        w_wait  = '0;
        w_state = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (r_wait == c_wait_last) begin
          w_rdata = mem_data_in;
          w_state = ST_EMIT;
          if (r_k != r_n) begin
            w_m_data  = mem_data_in;
            w_m_valid = 1'b1;
            w_m_last  = (r_k == (r_n - 9'd1));
          end
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end

      ST_EMIT: begin
        if (r_k != r_n) begin
          if (m_ready_in) begin
            w_m_valid  = 1'b0;
            w_m_last   = 1'b0;
            w_k        = r_k + 9'd1;
            w_mem_addr = c_out_base + {1'b0, w_k};
            w_state    = ST_RD_ISSUE;
          end
        end else begin
          // Word just past the payload must be the engine's terminator.
          if (r_rdata != c_term_word) begin
            w_err = 1'b1;
          end
          w_done  = 1'b1;
          w_state = ST_FIN;
        end
      end

      ST_FIN: begin
        w_n        = 9'd0;
        w_mem_addr = 10'd0;
        w_state    = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_n        <= 9'd0;
      r_k        <= 9'd0;
      r_wait     <= '0;
      r_mode     <= 1'b0;
      r_rdata    <= 32'h0;
      r_s_ready  <= 1'b0;
      r_m_data   <= 32'h0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_mem_addr <= 10'd0;
      r_mem_we   <= 4'h0;
      r_mem_data <= 32'h0;
      r_aes_ctrl <= 3'b000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_n        <= w_n;
      r_k        <= w_k;
      r_wait     <= w_wait;
      r_mode     <= w_mode;
      r_rdata    <= w_rdata;
      r_s_ready  <= (w_state == ST_IDLE) || (w_state == ST_LOAD);
      r_m_data   <= w_m_data;
      r_m_valid  <= w_m_valid;
      r_m_last   <= w_m_last;
      r_mem_addr <= w_mem_addr;
      r_mem_we   <= w_mem_we;
      r_mem_data <= w_mem_data;
      r_aes_ctrl <= w_aes_ctrl;
      r_busy     <= (w_state != ST_IDLE);
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign s_ready_out  = r_s_ready;
  assign m_data_out   = r_m_data;
  assign m_valid_out  = r_m_valid;
  assign m_last_out   = r_m_last;
  assign mem_addr_out = r_mem_addr;
  assign mem_we_out   = r_mem_we;
  assign mem_data_out = r_mem_data;
  assign aes_ctrl_out = r_aes_ctrl;
  assign busy_out     = r_busy;
  assign done_out     = r_done;
  assign err_out      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_mem_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_mem_driver
// Purpose  : Directed self-checking bench for aes_mem_driver. Models the
//            shared scratch memory (2-cycle read latency) and a toy engine
//            that writes the bitwise inverse of each input word to the
//            output region followed by the terminator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_mem_driver;

  localparam logic [31:0] c_term = 32'hDEADBEEF;
  localparam int          c_out  = 257;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mode_in;
  logic [31:0] s_data_in;
  logic        s_valid_in;
  logic        s_last_in;
  logic        s_ready_out;
  logic [31:0] m_data_out;
  logic        m_valid_out;
  logic        m_last_out;
  logic        m_ready_in;
  logic [9:0]  mem_addr_out;
  logic [3:0]  mem_we_out;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic [2:0]  aes_ctrl_out;
  logic        aes_complete_in;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  logic [31:0] mem [0:1023];
  logic [31:0] r_rd1, r_rd2;
  int          eng_idx;
  bit          bad_term;

  int          n_checks;
  int          n_fail;
  logic [31:0] in_words [0:299];
  logic [31:0] out_q [$];
  bit          last_q [$];
  int          wr_cnt;
  int          done_cnt;
  bit          ctrl_any;
  logic [2:0]  ctrl_seen;
  int          overlap_cnt;
  int          stall_idx = -1;
  int          stall_left;
  logic [31:0] stall_data;
  int          acc;

  aes_mem_driver #(
    .IN_BASE    (0),
    .OUT_BASE   (257),
    .MAX_WORDS  (256),
    .RD_LATENCY (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .mode_in         (mode_in),
    .s_data_in       (s_data_in),
    .s_valid_in      (s_valid_in),
    .s_last_in       (s_last_in),
    .s_ready_out     (s_ready_out),
    .m_data_out      (m_data_out),
    .m_valid_out     (m_valid_out),
    .m_last_out      (m_last_out),
    .m_ready_in      (m_ready_in),
    .mem_addr_out    (mem_addr_out),
    .mem_we_out      (mem_we_out),
    .mem_data_out    (mem_data_out),
    .mem_data_in     (mem_data_in),
    .aes_ctrl_out    (aes_ctrl_out),
    .aes_complete_in (aes_complete_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .err_out         (err_out)
  );

  always #5 clk_in = ~clk_in;

  assign mem_data_in = r_rd2;

  // Scratch memory plus engine: port owned by the driver while ctrl is zero.
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 + i;
      eng_idx         <= 0;
      aes_complete_in <= 1'b0;
    end else if (aes_ctrl_out == 3'b000) begin
      eng_idx         <= 0;
      aes_complete_in <= 1'b0;
      for (int b = 0; b < 4; b++)
        if (mem_we_out[b]) mem[mem_addr_out][8*b +: 8] <= mem_data_out[8*b +: 8];
    end else if (!aes_complete_in) begin
      if (mem[eng_idx] == c_term) begin
        mem[c_out + eng_idx] <= bad_term ? 32'h0BADBEEF : c_term;
        aes_complete_in      <= 1'b1;
      end else begin
        mem[c_out + eng_idx] <= ~mem[eng_idx];
        eng_idx              <= eng_idx + 1;
      end
    end
    r_rd1 <= mem[mem_addr_out];
    r_rd2 <= r_rd1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitors
  always @(negedge clk_in) begin
    if (mem_we_out != 4'h0) wr_cnt++;
    if (done_out) done_cnt++;
    if (aes_ctrl_out != 3'b000) begin
      ctrl_any  = 1'b1;
      ctrl_seen = aes_ctrl_out;
      if (mem_we_out != 4'h0) overlap_cnt++;
    end
  end

  // Result consumer with optional stall on one word index.
  always @(negedge clk_in) begin
    if (m_valid_out) begin
      if (out_q.size() == stall_idx && stall_left < 5)
        check_value("bp_stable", m_data_out, stall_data);
      if (out_q.size() == stall_idx && stall_left > 0) begin
        if (stall_left == 5) stall_data = m_data_out;
        stall_left--;
        m_ready_in = 1'b0;
      end else begin
        m_ready_in = 1'b1;
      end
      if (m_ready_in) begin
        out_q.push_back(m_data_out);
        last_q.push_back(m_last_out);
      end
    end else begin
      m_ready_in = 1'b1;
    end
  end

  task automatic clear_stats();
    @(posedge clk_in);
    #1;
    out_q.delete();
    last_q.delete();
    wr_cnt      = 0;
    done_cnt    = 0;
    ctrl_any    = 1'b0;
    ctrl_seen   = 3'b000;
    overlap_cnt = 0;
  endtask

  task automatic send_words(input int count, input bit mode, input bit with_last, output int accepted);
    int idle;
    accepted = 0;
    idle     = 0;
    while (accepted < count && idle < 20) begin
      @(negedge clk_in);
      s_valid_in = 1'b1;
      s_data_in  = in_words[accepted];
      s_last_in  = with_last && (accepted == count - 1);
      mode_in    = mode;
      if (s_ready_out) begin
        @(posedge clk_in);
        accepted++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    @(negedge clk_in);
    s_valid_in = 1'b0;
    s_last_in  = 1'b0;
    s_data_in  = 32'h0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(negedge clk_in);
      c++;
    end
    repeat (3) @(negedge clk_in);
    check_value(tag, done_cnt, 1);
  endtask

  task automatic check_outputs(input string tag, input int exp_cnt, input int last_idx);
    int n_last;
    n_last = 0;
    check_value({tag, "_out_cnt"}, out_q.size(), exp_cnt);
    foreach (last_q[i]) if (last_q[i]) n_last++;
    check_value({tag, "_last_cnt"}, n_last, (last_idx >= 0) ? 1 : 0);
    if (last_idx >= 0 && last_idx < last_q.size())
      check_value({tag, "_last_pos"}, {31'd0, last_q[last_idx]}, 1);
  endtask

  task automatic check_single_block(input string tag);
    check_outputs(tag, 4, 3);
    if (out_q.size() == 4) begin
      check_value({tag, "_r0"}, out_q[0], 32'hFFEEDDCC);
      check_value({tag, "_r1"}, out_q[1], 32'hBBAA9988);
      check_value({tag, "_r2"}, out_q[2], 32'h77665544);
      check_value({tag, "_r3"}, out_q[3], 32'h33221100);
    end
    check_value({tag, "_mem0"}, mem[0], 32'h00112233);
    check_value({tag, "_mem3"}, mem[3], 32'hCCDDEEFF);
    check_value({tag, "_mem4"}, mem[4], c_term);
    check_value({tag, "_ctrl"}, ctrl_seen, 3'b001);
    check_value({tag, "_writes"}, wr_cnt, 5);
    check_value({tag, "_overlap"}, overlap_cnt, 0);
  endtask

  task automatic load_block();
    in_words[0] = 32'h00112233;
    in_words[1] = 32'h44556677;
    in_words[2] = 32'h8899AABB;
    in_words[3] = 32'hCCDDEEFF;
  endtask

  initial begin
    logic [31:0] pad_exp [0:7];
    int          c;
    int          done_before;

    n_checks   = 0;
    n_fail     = 0;
    bad_term   = 1'b0;
    mode_in    = 1'b0;
    s_data_in  = 32'h0;
    s_valid_in = 1'b0;
    s_last_in  = 1'b0;
    rst_in     = 1'b0;
    #2 rst_in  = 1'b1;
    repeat (2) @(negedge clk_in);

    // Reset state
    check_value("rst_s_ready", s_ready_out, 0);
    check_value("rst_busy", busy_out, 0);
    check_value("rst_ctrl", aes_ctrl_out, 0);
    check_value("rst_we", mem_we_out, 0);
    check_value("rst_m_valid", m_valid_out, 0);
    check_value("rst_err_done", {err_out, done_out}, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check_value("idle_s_ready", s_ready_out, 1);

    // Single block, encrypt, with write/run timing
    load_block();
    clear_stats();
    send_words(4, 1'b0, 1'b1, acc);
    check_value("blk_accepted", acc, 4);
    check_value("blk_pad_s_ready", s_ready_out, 0);
    check_value("blk_busy", busy_out, 1);
    check_value("blk_last_wr_addr", mem_addr_out, 3);
    @(negedge clk_in);
    check_value("blk_term_addr", mem_addr_out, 4);
    check_value("blk_term_data", mem_data_out, c_term);
    check_value("blk_term_ctrl", aes_ctrl_out, 0);
    @(negedge clk_in);
    check_value("blk_run_ctrl", aes_ctrl_out, 3'b001);
    check_value("blk_run_we", mem_we_out, 0);
    wait_done("blk_done", 200);
    check_single_block("blk");
    check_value("blk_err", err_out, 0);
    check_value("blk_idle_busy", busy_out, 0);

    // Padding, decrypt
    in_words[0] = 32'h11111111;
    in_words[1] = 32'h22222222;
    in_words[2] = 32'h33333333;
    in_words[3] = 32'h44444444;
    in_words[4] = 32'h55555555;
    pad_exp = '{32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB,
                32'hAAAAAAAA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    clear_stats();
    send_words(5, 1'b1, 1'b1, acc);
    check_value("pad_accepted", acc, 5);
    wait_done("pad_done", 300);
    check_value("pad_mem5", mem[5], 0);
    check_value("pad_mem6", mem[6], 0);
    check_value("pad_mem7", mem[7], 0);
    check_value("pad_mem8", mem[8], c_term);
    check_value("pad_ctrl", ctrl_seen, 3'b010);
    check_value("pad_err", err_out, 0);
    check_outputs("pad", 8, 7);
    if (out_q.size() == 8)
      for (int i = 0; i < 8; i++) check_value("pad_word", out_q[i], pad_exp[i]);

    // Payload word equal to the terminator
    in_words[0] = 32'h01234567;
    in_words[1] = 32'h89ABCDEF;
    in_words[2] = c_term;
    clear_stats();
    send_words(3, 1'b0, 1'b0, acc);
    check_value("dbf_accepted", acc, 3);
    wait_done("dbf_done", 50);
    check_value("dbf_err", err_out, 1);
    check_value("dbf_no_run", ctrl_any, 0);
    check_value("dbf_writes", wr_cnt, 2);
    check_value("dbf_out_cnt", out_q.size(), 0);
    repeat (4) @(negedge clk_in);
    check_value("dbf_err_sticky", err_out, 1);

    // Backpressure on word 2 (also clears the sticky error)
    load_block();
    clear_stats();
    stall_idx  = 2;
    stall_left = 5;
    send_words(4, 1'b0, 1'b1, acc);
    check_value("bp_accepted", acc, 4);
    wait_done("bp_done", 300);
    check_value("bp_stall_used", stall_left, 0);
    stall_idx = -1;
    check_single_block("bp");
    check_value("bp_err", err_out, 0);

    // Overlong stream without last
    for (int i = 0; i < 260; i++) in_words[i] = 32'h10000000 + i;
    clear_stats();
    send_words(260, 1'b0, 1'b0, acc);
    check_value("max_accepted", acc, 256);
    wait_done("max_done", 3000);
    check_value("max_err", err_out, 1);
    check_value("max_writes", wr_cnt, 257);
    check_value("max_mem255", mem[255], 32'h100000FF);
    check_value("max_mem256", mem[256], c_term);
    check_outputs("max", 256, 255);
    if (out_q.size() == 256) begin
      check_value("max_first", out_q[0], 32'hEFFFFFFF);
      check_value("max_final", out_q[255], 32'hEFFFFF00);
    end

    // Bad terminator from the engine
    load_block();
    bad_term = 1'b1;
    clear_stats();
    send_words(4, 1'b0, 1'b1, acc);
    check_value("bad_accepted", acc, 4);
    wait_done("bad_done", 300);
    bad_term = 1'b0;
    check_value("bad_err", err_out, 1);
    check_value("bad_out_cnt", out_q.size(), 4);
    if (out_q.size() == 4) check_value("bad_r3", out_q[3], 32'h33221100);

    // Asynchronous reset during RUN
    load_block();
    clear_stats();
    send_words(4, 1'b0, 1'b1, acc);
    c = 0;
    while (aes_ctrl_out == 3'b000 && c < 20) begin
      @(negedge clk_in);
      c++;
    end
    check_value("ar_in_run", aes_ctrl_out, 3'b001);
    done_before = done_cnt;
    #2 rst_in = 1'b1;
    #1;
    check_value("ar_ctrl", aes_ctrl_out, 0);
    check_value("ar_busy", busy_out, 0);
    check_value("ar_err", err_out, 0);
    check_value("ar_we_valid", {mem_we_out, m_valid_out, s_ready_out, done_out}, 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_value("ar_no_done", done_cnt, done_before);
    clear_stats();
    send_words(4, 1'b0, 1'b1, acc);
    check_value("ar2_accepted", acc, 4);
    wait_done("ar2_done", 300);
    check_single_block("ar2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
